program_memory_mc: RTL

- Shared program-word memory for the multi-core logic unit: one block-RAM array serves NUM_CORES instruction-fetch channels through a round-robin arbiter.
- Reads are registered: one-cycle latency from grant to data.
- A streaming loader state machine fills the array from the host side before or between runs.
- Replaces the single-port, combinational-read program memory for multi-core builds.

---
 rtl/program_memory_mc.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/program_memory_mc.sv
// rtl/program_memory_mc.sv - shared multi-core program memory with round-robin fetch arbiter and streaming loader
// Purpose: one program-word array serving NUM_CORES fetch channels (registered reads,
//          one-cycle grant-to-data latency) and filled by a host-side streaming loader.
// Ports:   CLK, RST_N (sync active-low); REQ/ADDR per-core fetch in; GNT (comb one-hot),
//          VALID/DQ per-core registered fetch out; LD_START/LD_VALID/LD_DATA/LD_LAST loader in;
//          LD_READY/BUSY (in LOAD), LD_OVF (sticky pointer wrap), PERR (fetch parity error).
// Option:  PMC_PARITY_EN - store an even-parity bit per word and check it on every fetch.
module program_memory_mc #(
    parameter int IA_W      = 16,
    parameter int ID_W      = 24,
    parameter int NUM_CORES = 4
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic [NUM_CORES-1:0]      REQ,
    input  logic [NUM_CORES*IA_W-1:0] ADDR,
    output logic [NUM_CORES-1:0]      GNT,
    output logic [NUM_CORES-1:0]      VALID,
    output logic [NUM_CORES*ID_W-1:0] DQ,
    input  logic                      LD_START,
    input  logic                      LD_VALID,
    input  logic [ID_W-1:0]           LD_DATA,
    input  logic                      LD_LAST,
    output logic                      LD_READY,
    output logic                      LD_OVF,
    output logic                      BUSY,
    output logic                      PERR
);
    localparam int MEM_SIZE = 1 << IA_W;
    localparam int CW       = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
`ifdef PMC_PARITY_EN
    localparam int MW = ID_W + 1;
`else
    localparam int MW = ID_W;
`endif

    localparam logic [0:0] S_RUN  = 1'b0;
    localparam logic [0:0] S_LOAD = 1'b1;

    logic [0:0]                state;
    logic [CW-1:0]             ptr;
    logic [IA_W-1:0]           wptr;
    logic                      ovf;
    logic [MW-1:0]             mem [MEM_SIZE];
    logic [NUM_CORES-1:0]      valid_q;
    logic [NUM_CORES*ID_W-1:0] dq_q;

    logic                      wr_en;
    logic [MW-1:0]             wr_word;
    logic                      gfound;
    logic [CW-1:0]             gidx;
    logic [CW-1:0]             cand;
    logic [IA_W-1:0]           gaddr;
    logic [MW-1:0]             rd_word;

    // LD_START takes priority over a word offered in the same cycle.
    assign wr_en = RST_N && (state == S_LOAD) && LD_VALID && !LD_START;

`ifdef PMC_PARITY_EN
    assign wr_word = {^LD_DATA, LD_DATA};
`else
    assign wr_word = LD_DATA;
`endif

    // Array has no reset so contents survive reset and reloads.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wptr] <= wr_word;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= S_RUN;
            wptr  <= '0;
            ovf   <= 1'b0;
        end else if (LD_START) begin
            state <= S_LOAD;
            wptr  <= '0;
            ovf   <= 1'b0;
        end else if (wr_en) begin
            wptr <= wptr + 1'b1;
            if (wptr == {IA_W{1'b1}}) begin
                ovf <= 1'b1;
            end
            if (LD_LAST) begin
                state <= S_RUN;
            end
        end
    end

    // Round-robin: first requester at or above ptr, wrapping modulo NUM_CORES.
    always_comb begin
        gfound = 1'b0;
        gidx   = '0;
        cand   = '0;
        if (state == S_RUN) begin
            for (int j = 0; j < NUM_CORES; j++) begin
                cand = CW'((int'(ptr) + j) % NUM_CORES);
                if (!gfound && REQ[cand]) begin
                    gfound = 1'b1;
                    gidx   = cand;
                end
            end
        end
    end

    assign GNT     = gfound ? (NUM_CORES'(1) << gidx) : '0;
    assign gaddr   = ADDR[gidx*IA_W +: IA_W];
    assign rd_word = mem[gaddr];

`ifdef PMC_PARITY_EN
    logic [MW-1:0] chk_word;
`endif

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            ptr     <= '0;
            valid_q <= '0;
            dq_q    <= '0;
`ifdef PMC_PARITY_EN
            chk_word <= '0;
`endif
        end else begin
            valid_q <= GNT;
            if (gfound) begin
                ptr <= (gidx == CW'(NUM_CORES - 1)) ? '0 : gidx + 1'b1;
                dq_q[gidx*ID_W +: ID_W] <= rd_word[ID_W-1:0];
`ifdef PMC_PARITY_EN
                chk_word <= rd_word;
`endif
            end
        end
    end

`ifdef PMC_PARITY_EN
    // Stored word plus its parity bit must XOR to zero.
    assign PERR = (|valid_q) & (^chk_word);
`else
    assign PERR = 1'b0;
`endif

    assign VALID    = valid_q;
    assign DQ       = dq_q;
    assign LD_OVF   = ovf;
    assign BUSY     = (state == S_LOAD);
    assign LD_READY = (state == S_LOAD);

endmodule
